// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, instruction-memory read handshake with timeout,
// instruction register and next-PC selection for jump / taken branch / sequential flow.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic        instr_valid,
   input  logic        exec_done,
   input  logic        branch,
   input  logic        jump,
   input  logic        br_cond,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_HOLD,
      S_ERR
   } state_t;

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
   localparam logic [7:0]  TIMEOUT_W        = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [7:0]  wait_q, wait_d;

   logic [31:0] seq_pc;
   logic [31:0] jump_target;
   logic [31:0] branch_target;
   logic [7:0]  wait_inc;

   assign seq_pc        = pc_q + 32'd4;
   assign jump_target   = {seq_pc[31:28], instr_q[25:0], 2'b00};
   assign branch_target = seq_pc + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
   assign wait_inc      = wait_q + 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC_ALIGNED;
         instr_q <= 32'd0;
         wait_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      wait_d  = wait_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            wait_d  = 8'd0;
         end
         S_FETCH: begin
            // A response on the timeout edge still wins over the fault.
            if (imem_ready) begin
               instr_d = imem_rdata;
               state_d = S_HOLD;
               wait_d  = 8'd0;
            end else begin
               wait_d = wait_inc;
               if (wait_inc == TIMEOUT_W) begin
                  state_d = S_ERR;
               end
            end
         end
         S_HOLD: begin
            if (exec_done) begin
               state_d = S_FETCH;
               wait_d  = 8'd0;
               // Jump checked first: the control unit raises branch alongside J.
               if (jump) begin
                  pc_d = jump_target;
               end else if (branch && br_cond) begin
                  pc_d = branch_target;
               end else begin
                  pc_d = seq_pc;
               end
            end
         end
         default: begin
            state_d = S_ERR;
         end
      endcase
   end

   assign imem_req    = (state_q == S_FETCH);
   assign imem_addr   = pc_q;
   assign instr_valid = (state_q == S_HOLD);
   assign fetch_err   = (state_q == S_ERR);
   assign instr       = instr_q;
   assign opcode      = instr_q[31:26];
   assign funct       = instr_q[5:0];
   assign pc          = pc_q;
   assign pc_plus4    = seq_pc;

endmodule
